// File: rtl/xadac_pkg.sv
// Shared constants and helpers for xadac datapath blocks.
package xadac_pkg;

    // Legal storage depth range for xadac elastic buffers.
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 256;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer addressing depth entries; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/xadac_elastic_buf.sv
// Elastic buffer for xadac valid/ready channels: circular storage of Depth
// entries, optional fall-through when empty, synchronous flush, occupancy out.
//
// Handshake: a word transfers on a rising clk edge when valid and ready are
// both high on that side. A source may not make valid depend on ready.
// slv_ready is a function of registered state and flush only, so there is no
// combinational path from mst_ready to slv_ready in any mode.
module xadac_elastic_buf
    import xadac_pkg::*;
#(
    parameter type         DataT       = logic,
    parameter int unsigned Depth       = 2,
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned CntW        = cnt_width(Depth)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  DataT            slv_data,
    input  logic            slv_valid,
    output logic            slv_ready,
    output DataT            mst_data,
    output logic            mst_valid,
    input  logic            mst_ready,
    output logic [CntW-1:0] usage
);

    localparam int unsigned     PtrW     = ptr_width(Depth);
    localparam logic [PtrW-1:0] LAST_PTR = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FULL_CNT = CntW'(Depth);

    DataT            mem [Depth];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;

    logic full;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_adv;

    // Advance a pointer, wrapping explicitly so non-power-of-2 depths work.
    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Status, handshake decode and output muxing (bypass only when empty).
    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        bypass    = FallThrough && empty && !flush;
        slv_ready = !full && !flush;
        if (bypass) begin
            mst_valid = slv_valid;
            mst_data  = slv_data;
        end else begin
            mst_valid = !empty && !flush;
            mst_data  = mem[rd_ptr];
        end
        push   = slv_valid && slv_ready;
        pop    = mst_valid && mst_ready;
        // A bypassed word is consumed straight through: never stored, never counted.
        wr_en  = push && !(bypass && mst_ready);
        rd_adv = pop && !bypass;
    end

    // Pointer, count and storage update; flush outranks push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Contents are left in place; only the bookkeeping is cleared.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= slv_data;
                wr_ptr      <= ptr_incr(wr_ptr);
            end
            if (rd_adv) begin
                rd_ptr <= ptr_incr(rd_ptr);
            end
            case ({wr_en, rd_adv})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign usage = count;

    // Reject illegal depths at elaboration.
    if (Depth < DEPTH_MIN || Depth > DEPTH_MAX) begin : g_depth_chk
        $error("xadac_elastic_buf: Depth %0d outside %0d..%0d", Depth, DEPTH_MIN, DEPTH_MAX);
    end

    // Occupancy can never exceed the storage size.
    a_count_le_depth : assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT)
        else $error("xadac_elastic_buf: count exceeds Depth");

endmodule

// File: tb/tb_xadac_elastic_buf.sv
// Bench for xadac_elastic_buf: four configurations (Depth 4, Depth 3,
// Depth 2 fall-through, Depth 1) checked by a queue-based scoreboard and an
// occupancy/handshake model derived from the buffer's contract.
module tb_xadac_elastic_buf;

    typedef logic [15:0] word_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- stimulus side (index: 0=D4, 1=D3, 2=D2 FT, 3=D1) ----
    logic  flush_i [4];
    logic  sv      [4];
    word_t sd      [4];
    logic  mr      [4];

    // ---------------- DUT outputs ----------------
    logic       sr0, sr1, sr2, sr3;
    logic       mv0, mv1, mv2, mv3;
    word_t      md0, md1, md2, md3;
    logic [2:0] us0;
    logic [1:0] us1;
    logic [1:0] us2;
    logic [0:0] us3;

    // ---------------- scoreboard state ----------------
    word_t exp_q [4][$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    rcv [4] = '{default: 0};

    xadac_elastic_buf #(.DataT(word_t), .Depth(4), .FallThrough(1'b0)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush_i[0]),
        .slv_data(sd[0]), .slv_valid(sv[0]), .slv_ready(sr0),
        .mst_data(md0), .mst_valid(mv0), .mst_ready(mr[0]), .usage(us0));

    xadac_elastic_buf #(.DataT(word_t), .Depth(3), .FallThrough(1'b0)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush_i[1]),
        .slv_data(sd[1]), .slv_valid(sv[1]), .slv_ready(sr1),
        .mst_data(md1), .mst_valid(mv1), .mst_ready(mr[1]), .usage(us1));

    xadac_elastic_buf #(.DataT(word_t), .Depth(2), .FallThrough(1'b1)) u_ft (
        .clk(clk), .rst(rst), .flush(flush_i[2]),
        .slv_data(sd[2]), .slv_valid(sv[2]), .slv_ready(sr2),
        .mst_data(md2), .mst_valid(mv2), .mst_ready(mr[2]), .usage(us2));

    xadac_elastic_buf #(.DataT(word_t), .Depth(1), .FallThrough(1'b0)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush_i[3]),
        .slv_data(sd[3]), .slv_valid(sv[3]), .slv_ready(sr3),
        .mst_data(md3), .mst_valid(mv3), .mst_ready(mr[3]), .usage(us3));

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // At each edge: accepted words enter the expected queue, delivered words
    // leave it and are compared. Flush and reset empty the queue.
    task automatic sb_edge(input int k, input logic fl, input logic v, input logic r,
                           input word_t d, input logic ov, input logic orr, input word_t od);
        if (rst || fl) begin
            exp_q[k].delete();
            return;
        end
        if (v && r) exp_q[k].push_back(d);
        if (ov && orr) begin
            if (exp_q[k].size() == 0) begin
                check($sformatf("pop_when_empty%0d", k), 1, 0);
            end else begin
                check($sformatf("data%0d", k), od, exp_q[k].pop_front());
                rcv[k]++;
            end
        end
    endtask

    // Between edges: what the outputs must be for the current model occupancy.
    task automatic model_chk(input int k, input int depth, input bit ft, input logic fl,
                             input logic v, input word_t d, input logic r, input logic ov,
                             input word_t od, input int us);
        int    sz;
        logic  e_mv;
        word_t e_md;
        sz = exp_q[k].size();
        check($sformatf("usage%0d", k), us, sz);
        check($sformatf("slv_ready%0d", k), r, int'((sz < depth) && !fl));
        if (ft && sz == 0 && !fl) begin
            e_mv = v;
            e_md = d;
        end else begin
            e_mv = (sz > 0) && !fl;
            e_md = (sz > 0) ? exp_q[k][0] : '0;
        end
        check($sformatf("mst_valid%0d", k), ov, e_mv);
        if (e_mv) check($sformatf("mst_data%0d", k), od, e_md);
    endtask

    // Monitor: consume handshakes on the active edge.
    always @(posedge clk) begin
        sb_edge(0, flush_i[0], sv[0], sr0, sd[0], mv0, mr[0], md0);
        sb_edge(1, flush_i[1], sv[1], sr1, sd[1], mv1, mr[1], md1);
        sb_edge(2, flush_i[2], sv[2], sr2, sd[2], mv2, mr[2], md2);
        sb_edge(3, flush_i[3], sv[3], sr3, sd[3], mv3, mr[3], md3);
    end

    // Monitor: compare steady-state outputs against the model on the far edge.
    always @(negedge clk) begin
        if (!rst) begin
            model_chk(0, 4, 1'b0, flush_i[0], sv[0], sd[0], sr0, mv0, md0, int'(us0));
            model_chk(1, 3, 1'b0, flush_i[1], sv[1], sd[1], sr1, mv1, md1, int'(us1));
            model_chk(2, 2, 1'b1, flush_i[2], sv[2], sd[2], sr2, mv2, md2, int'(us2));
            model_chk(3, 1, 1'b0, flush_i[3], sv[3], sd[3], sr3, mv3, md3, int'(us3));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int    sent;
    int    cyc;
    int    took_n;
    bit    took;
    word_t nxt;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            flush_i[k] = 1'b0;
            sv[k]      = 1'b0;
            sd[k]      = '0;
            mr[k]      = 1'b0;
        end

        // Reset then idle.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_slv_ready_d4", sr0, 1);
        check("rst_mst_valid_d4", mv0, 0);
        check("rst_usage_d4", int'(us0), 0);
        check("rst_mst_data_d4", md0, 0);
        check("rst_mst_data_d3", md1, 0);
        check("rst_usage_d1", int'(us3), 0);

        // Depth 4 fill under backpressure, then drain in order.
        for (int i = 0; i < 4; i++) begin
            sd[0] = word_t'(16'h11 * (i + 1));
            sv[0] = 1'b1;
            step();
            check("fill_usage", int'(us0), i + 1);
        end
        sv[0] = 1'b0;
        #1;
        check("full_slv_ready", sr0, 0);
        check("full_head", md0, 16'h11);
        mr[0] = 1'b1;
        step();
        check("ready_after_pop", sr0, 1);
        repeat (4) step();
        mr[0] = 1'b0;
        check("drain_rcv", rcv[0], 4);
        check("drain_usage", int'(us0), 0);

        // Flush with three held words, racing a push and a pop.
        for (int i = 0; i < 3; i++) begin
            sd[0] = word_t'(16'h31 + i);
            sv[0] = 1'b1;
            step();
        end
        flush_i[0] = 1'b1;
        sd[0]      = 16'h99;
        mr[0]      = 1'b1;
        #1;
        check("flush_slv_ready", sr0, 0);
        check("flush_mst_valid", mv0, 0);
        step();
        flush_i[0] = 1'b0;
        sv[0]      = 1'b0;
        mr[0]      = 1'b0;
        #1;
        check("post_flush_usage", int'(us0), 0);
        check("post_flush_mst_valid", mv0, 0);
        check("post_flush_slv_ready", sr0, 1);
        check("flush_rcv", rcv[0], 4);

        // Fall-through: bypass when downstream ready, store when stalled.
        sd[2] = 16'hA5;
        sv[2] = 1'b1;
        mr[2] = 1'b1;
        #1;
        check("ft_bypass_valid", mv2, 1);
        check("ft_bypass_data", md2, 16'hA5);
        check("ft_bypass_usage", int'(us2), 0);
        step();
        check("ft_bypass_usage_after", int'(us2), 0);
        check("ft_bypass_rcv", rcv[2], 1);
        mr[2] = 1'b0;
        step();
        sv[2] = 1'b0;
        #1;
        check("ft_store_usage", int'(us2), 1);
        check("ft_store_valid", mv2, 1);
        check("ft_store_data", md2, 16'hA5);
        mr[2] = 1'b1;
        step();
        mr[2] = 1'b0;
        check("ft_drain_usage", int'(us2), 0);

        // Fall-through random traffic.
        for (int c = 0; c < 2000; c++) begin
            sv[2] = 1'($urandom_range(0, 1));
            sd[2] = word_t'($urandom);
            mr[2] = 1'($urandom_range(0, 1));
            step();
        end
        sv[2] = 1'b0;
        mr[2] = 1'b1;
        repeat (3) step();
        mr[2] = 1'b0;
        check("ft_rnd_leftover", exp_q[2].size(), 0);

        // Depth 3 random valid/ready, incrementing payload.
        sent = 0;
        cyc  = 0;
        nxt  = '0;
        while (sent < 10000 && cyc < 60000) begin
            if (!sv[1] && $urandom_range(0, 3) != 0) begin
                sv[1] = 1'b1;
                sd[1] = nxt;
            end
            mr[1] = ($urandom_range(0, 3) != 0);
            #3;
            took = sv[1] && sr1;
            step();
            if (took) begin
                sent++;
                nxt++;
                sv[1] = 1'b0;
            end
            cyc++;
        end
        check("d3_send_budget", sent, 10000);
        sv[1] = 1'b0;
        mr[1] = 1'b1;
        repeat (5) step();
        mr[1] = 1'b0;
        check("d3_rcv_total", rcv[1], 10000);
        check("d3_leftover", exp_q[1].size(), 0);

        // Depth 1 under continuous flow: one word every two cycles.
        sd[3]  = 16'h100;
        sv[3]  = 1'b1;
        mr[3]  = 1'b1;
        took_n = 0;
        for (int c = 0; c < 20; c++) begin
            #3;
            took = sv[3] && sr3;
            step();
            if (took) begin
                took_n++;
                sd[3] = sd[3] + 1'b1;
            end
        end
        check("d1_rate", took_n, 10);

        // Async reset while holding a word.
        cyc = 0;
        while (us3 != 1'b1 && cyc < 4) begin
            step();
            cyc++;
        end
        check("d1_holding", int'(us3), 1);
        sv[3] = 1'b0;
        mr[3] = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_usage", int'(us3), 0);
        check("arst_mst_valid", mv3, 0);
        check("arst_slv_ready", sr3, 1);
        check("arst_mst_data", md3, 0);
        step();
        rst = 1'b0;
        step();
        check("post_arst_usage", int'(us3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xadac_elastic_buf.md
Name: xadac_elastic_buf

Overview:
- Parametrised elastic buffer for valid/ready channels in the xadac datapath.
- It is the successor of the two-entry register cut. It adds configurable depth, an optional fall-through (zero-latency) mode, a synchronous flush and an occupancy output.
- It sits between xadac pipeline stages and on request/response channels to decouple timing and absorb bursts.
- In registered mode, no combinational path exists from mst_ready to slv_ready.

Parameters:
- DataT, logic: payload type carried on the channel.
- Depth, 2: number of storage entries; legal values 1..256.
- FallThrough, 1'b0: 1 = an empty buffer forwards slv_data combinationally to mst.
- CntW, $clog2(Depth+1): width of usage; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of all entries.
- slv_data  in  DataT  upstream payload.
- slv_valid  in  1  upstream valid.
- slv_ready  out  1  upstream ready.
- mst_data  out  DataT  downstream payload.
- mst_valid  out  1  downstream valid.
- mst_ready  in  1  downstream ready.
- usage  out  CntW  number of stored entries.

Behaviour:
- Reset values, with rst asynchronous and active-high:
  - rd_ptr, wr_ptr and count = 0.
  - Storage = '0.
  - Outputs: mst_valid = 0 and mst_data = '0 (FallThrough=0), usage = 0, slv_ready = 1. Upstream must hold slv_valid low while rst is high.
- Storage: circular array of Depth entries.
  - Pointer width is max(1, $clog2(Depth)).
  - Pointers wrap from Depth-1 to 0; non-power-of-2 Depth is supported by explicit compare.
- Status and ready/valid:
  - full = (count == Depth); empty = (count == 0).
  - slv_ready = !full && !flush. It depends on registered state only, never on mst_ready.
  - Registered mode (FallThrough=0 or not empty): mst_valid = !empty && !flush; mst_data = entry[rd_ptr].
- Push and pop:
  - push = slv_valid && slv_ready.
  - pop = mst_valid && mst_ready.
- Per cycle, when not flushing:
  - Push writes entry[wr_ptr] and advances wr_ptr.
  - Pop advances rd_ptr.
  - count += push − pop. Simultaneous push and pop leaves count unchanged; this is legal at any non-full occupancy.
  - When full, push is impossible (slv_ready=0) even if mst_ready=1 that cycle.
- Latency and throughput:
  - Registered mode: a word pushed in cycle N is visible on mst in cycle N+1.
  - Sustained throughput is 1 word/cycle for Depth ≥ 2. Depth=1 gives at most 1 word every 2 cycles under continuous backpressure-free flow.
- Fall-through mode (FallThrough=1), when empty and not flushing:
  - mst_valid = slv_valid and mst_data = slv_data.
  - If mst_ready=1, the word bypasses: no write, count stays 0.
  - If mst_ready=0, the word is written as a normal push and appears registered next cycle.
  - Order is always preserved; bypass only occurs when empty.
- Flush:
  - While flush=1: slv_ready=0 and mst_valid=0; no handshake completes.
  - On the next edge: pointers and count = 0. Storage contents are not cleared.
  - flush takes priority over push and pop in the same cycle.
- usage equals count (registered). Bypassed words are never counted.
- mst_data when mst_valid=0 is don't-care in the contract, but is deterministic ('0 after reset).
- Assertions:
  - Depth in range.
  - count ≤ Depth.
  - slv_data stable while slv_valid && !slv_ready is not checked here; that belongs to the upstream protocol checker.

Decomposition:
- Depth limits and the CntW derivation helper function go in xadac_pkg.
- DataT stays a parameter; no channel typedef is added for this block.
- Single module, no sub-module. Pointer increment-with-wrap is a local function.
- Depth=2, FallThrough=0 is the drop-in replacement for the existing cut.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release → slv_ready=1, mst_valid=0, usage=0, mst_data=0.
- Depth=4, mst_ready=0, push 0x11,0x22,0x33,0x44 → usage 1,2,3,4; slv_ready=0 after the 4th; then mst_ready=1 → 0x11..0x44 drain in order, slv_ready=1 one cycle after the first pop.
- Depth=3, random valid/ready 10k words, incrementing payload → scoreboard order exact; pointer wrap exercised; never more than 3 in flight; no word lost or duplicated.
- FallThrough=1, empty, slv_valid=1 with 0xA5, mst_ready=1 → same cycle mst_valid=1, mst_data=0xA5, usage stays 0; repeat with mst_ready=0 → usage=1 next cycle, 0xA5 held.
- Depth=4 holding 3 words, flush=1 for 1 cycle together with slv_valid=1 and mst_ready=1 → no handshake that cycle; next cycle usage=0, mst_valid=0, slv_ready=1.
- Depth=1: continuous slv_valid, mst_ready=1 → alternating push/pop, 1 word per 2 cycles. Also assert rst mid-stream with usage=1 → outputs return to reset values immediately, asynchronously.
